// File: rtl/mc_main_control.sv
// mc_main_control: multicycle MIPS main control FSM.
// Steps each instruction through fetch, decode, execute, memory and writeback
// states, decodes every datapath enable and select from the registered state,
// and counts retired instructions.
// Optional build macro MC_ILLEGAL_OP_TRAP_EN adds a TRAP state and the
// illegal_op output; without it, undefined opcodes retire nothing and act as a NOP.
module mc_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    output logic [2:0]       ALUOP,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
`ifdef MC_ILLEGAL_OP_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [3:0]       state_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
`ifdef MC_ILLEGAL_OP_TRAP_EN
        ,S_TRAP  = 4'd12
`endif
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;

    assign state_o = state;

    // State, latched opcode and retirement counter; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (reset) begin
            state       <= S_FETCH;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            if (instr_done) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Moore decode of next state and datapath controls from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // the block leaves a signal unassigned, which would infer a latch.
        state_nxt   = S_FETCH;
        ALUOP       = 3'b000;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
`ifdef MC_ILLEGAL_OP_TRAP_EN
        illegal_op  = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                MemRead   = 1'b1;
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b01;
                ALUOP     = 3'b100;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOP   = 3'b100;
                case (opcode)
                    OP_LW, OP_SW:               state_nxt = S_MEMADR;
                    OP_R:                       state_nxt = S_REXEC;
                    OP_BEQ:                     state_nxt = S_BRANCH;
                    OP_J:                       state_nxt = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_nxt = S_IEXEC;
`ifdef MC_ILLEGAL_OP_TRAP_EN
                    default:                    state_nxt = S_TRAP;
`else
                    default:                    state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOP     = 3'b100;
                state_nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = 1'b1;
            end
            S_REXEC: begin
                ALUSrcA   = 1'b1;
                ALUOP     = 3'b010;
                state_nxt = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = 3'b111;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                state_nxt = S_IWB;
                case (op_q)
                    OP_ANDI: ALUOP = 3'b101;
                    OP_ORI:  ALUOP = 3'b110;
                    default: ALUOP = 3'b100;
                endcase
            end
            S_IWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MC_ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
                state_nxt  = S_TRAP;
            end
`endif
            default: state_nxt = S_FETCH;
        endcase

        // Reset kills every enable immediately so an aborted instruction writes nothing.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
        end
    end

endmodule
